// File: rtl/jtopl_snd_i2s.sv
// I2S serialiser for the FM accumulator output. It captures one signed 16-bit
// sample per FM frame into a small FIFO and sends it on both stereo channels.
module jtopl_snd_i2s #(
  parameter int DEPTH    = 4,
  parameter int BCLK_DIV = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cenop,
  input  logic                     zero,
  input  logic [15:0]              snd,
  output logic                     bclk,
  output logic                     lrck,
  output logic                     sdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic          strobe_q;
  logic [7:0]    div_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    bit_nxt;
  logic [15:0]   held;
  logic [15:0]   held_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          div_wrap;
  logic          fall;
  logic          pop_slot;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_write;

  assign div_wrap   = (div_cnt == 8'(BCLK_DIV - 1));
  assign fall       = div_wrap & bclk;
  assign bit_nxt    = bit_cnt + 5'd1;
  // The new sample is loaded once the previous frame's right LSB is out (b=0).
  assign pop_slot   = fall & (bit_nxt == 5'd1);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign do_pop     = pop_slot & ~fifo_empty;
  assign do_write   = strobe_q & (~fifo_full | do_pop);
  assign held_nxt   = do_pop ? mem[rd_ptr] : held;

  // Sample storage needs no reset: an entry is always written before it is read.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= snd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= 1'b0;
      div_cnt  <= '0;
      bclk     <= 1'b0;
      bit_cnt  <= '0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      held     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      strobe_q <= cenop & zero;
      div_cnt  <= div_wrap ? '0 : div_cnt + 8'd1;
      if (div_wrap) bclk <= ~bclk;
      // One-bit I2S delay: bit (31 - old b) of {S,S}, i.e. S[15 - (old b mod 16)].
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrck    <= bit_nxt[4];
        sdata   <= held_nxt[~bit_cnt[3:0]];
        held    <= held_nxt;
      end
      if (pop_slot & fifo_empty) underrun <= 1'b1;
      if (strobe_q & ~do_write)  overrun  <= 1'b1;
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: doc/jtopl_snd_i2s.md
Name: jtopl_snd_i2s

Overview:
- Consumer end of the accumulator's sound output.
- Captures one signed 16-bit mixed sample per FM frame, marked by the frame-boundary strobe, into a small FIFO.
- Serialises the samples as mono-duplicated stereo I2S for an external DAC or host audio path.
- Decouples the FM sample rate from the I2S frame rate and flags over/underruns.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- BCLK_DIV, 8, clk cycles per bclk half-period; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- cenop  in  1  operator clock enable, same as the accumulator's
- zero  in  1  frame-boundary marker, same as the accumulator's
- snd  in  16  signed mixed sample from the accumulator
- bclk  out  1  I2S bit clock
- lrck  out  1  I2S word select; 0 = left, 1 = right
- sdata  out  1  I2S serial data, MSB first
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overrun  out  1  sticky; a sample was dropped because the FIFO was full
- underrun  out  1  sticky; a frame was sent with an empty FIFO

Behaviour:
- Reset (rst=0, asynchronous) forces: bclk=0, lrck=0, sdata=0, level=0, overrun=0, underrun=0, bit counter=0, divider=0, held sample=0. FIFO pointers clear.
- Capture:
  - strobe_q <= cenop & zero, registered each clk.
  - In the cycle where strobe_q=1, snd is written to the FIFO. snd is stable at least one clk after the cenop&zero cycle.
  - One write per strobe_q pulse.
- Full FIFO on write: sample discarded, overrun set to 1, pointers and contents unchanged.
- Divider:
  - Counts 0..BCLK_DIV-1; bclk toggles on wrap.
  - A "fall" event is the clk cycle in which bclk goes 1->0.
- Bit counter b: 5 bits, advances on each fall, wraps 31->0.
- lrck and sdata update only on fall events:
  - lrck = 1 for b in 16..31, else 0.
  - sdata = bit (31 - ((b-1) mod 32)) of frame word F = {S,S}, S = current held sample. This is standard I2S one-bit delay: left MSB at b=1, right LSB at b=0 of the following frame.
- Pop, on the fall where b becomes 1, after the old F's final bit has been emitted at b=0:
  - FIFO non-empty: S <= head, head removed.
  - FIFO empty: S retained (last sample repeats), underrun set to 1.
- Simultaneous write and pop in the same clk: both occur. level unchanged; a full FIFO accepts the write because the pop frees a slot (no overrun).
- level is the registered occupancy after that cycle's write/pop.
- Sticky flags clear only on reset.
- Sample values pass through bit-exact; no rescaling or saturation (snd is already saturated upstream).
- Reset asserted mid-frame: outputs go to reset values immediately. After release, serialisation restarts at b=0 with S=0, so the first transmitted frame is zero unless a pop has loaded a sample.

Test Plan:
- Reset release, no strobes, BCLK_DIV=1 -> bclk period 2 clk; lrck toggles every 16 bclk; sdata always 0; underrun=1 after first pop point; level=0.
- Single capture snd=16'h8001 (cenop=zero=1 one cycle) -> level=1 two clk later; after next pop, left bits b=1..16 read 1000_0000_0000_0001, right slot identical; level=0.
- 6 strobes with values 1..6, DEPTH=4, no pops (BCLK_DIV=255, strobes inside one frame) -> level=4, overrun=1, later pops yield 1,2,3,4.
- Write coinciding with pop while level=4 -> level stays 4, overrun stays 0, popped value is oldest entry.
- FIFO drained, then empty frames -> last sample 16'h7FFF repeats on both channels; underrun=1.
- Assert rst mid-word (b=9) -> bclk, lrck, sdata, level, flags =0 asynchronously; after release the first frame is all zeros.
